// File: rtl/psg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// psg_bus_arbiter
//
// Shares the write side of a TurboSound pair of YM2149 SSGs between the Z80
// port decoder and an autonomous replay engine. Each request becomes a
// sequence of BDIR pulses on the common BDIR/BC/DI bus, and psg_a8 picks the
// target chip. Each BDIR pulse is followed by one idle gap cycle.
//
// The CPU's view of each chip is protected:
//   - the TurboSound chip select (FF/FE written to the address port) is
//     tracked here and never reaches the bus;
//   - a per-chip shadow holds the register number the CPU last selected;
//   - every replay write ends with a restore pulse that latches that shadow
//     value again, so the CPU's latched address never appears disturbed.
//
// Handshake (replay side): a request transfers on a rising CLK edge where
// rp_valid and rp_ready are both high. rp_ready is combinational. It is high
// only when the arbiter is idle, no CPU write is pending, and no CPU write
// strobe is present this cycle, so the CPU always wins a tie. rp_* fields are
// sampled only on that edge. The CPU side has no back-pressure: a cpu_wr that
// finds the single pending slot occupied is dropped, and cpu_ovr is set.
//
// Ports:
//   CLK, RESET     system clock; synchronous active-high reset
//   cpu_wr         one-cycle CPU write strobe
//   cpu_sel_addr   with cpu_wr: 1 = register-select port, 0 = data port
//   cpu_di[7:0]    CPU write data
//   rp_valid       replay request valid
//   rp_ready       replay request can be accepted this cycle
//   rp_chip        replay target chip
//   rp_reg[3:0]    replay target register
//   rp_data[7:0]   replay write data
//   psg_bdir       BDIR to both chips (registered)
//   psg_bc         BC to both chips (registered)
//   psg_do[7:0]    DI to both chips (registered); holds the op byte
//                  through its gap cycle
//   psg_a8[1:0]    per-chip A8, one-hot during a pulse, else 0 (registered)
//   rd_chip        current CPU chip select, steers the read mux (registered)
//   cpu_ovr        sticky: a CPU write was dropped (registered)
// -----------------------------------------------------------------------------
module psg_bus_arbiter (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       cpu_wr,
   input  logic       cpu_sel_addr,
   input  logic [7:0] cpu_di,
   input  logic       rp_valid,
   output logic       rp_ready,
   input  logic       rp_chip,
   input  logic [3:0] rp_reg,
   input  logic [7:0] rp_data,
   output logic       psg_bdir,
   output logic       psg_bc,
   output logic [7:0] psg_do,
   output logic [1:0] psg_a8,
   output logic       rd_chip,
   output logic       cpu_ovr
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      CPU_OP  = 4'd1,
      CPU_GAP = 4'd2,
      R_ADDR  = 4'd3,
      R_GAP1  = 4'd4,
      R_DATA  = 4'd5,
      R_GAP2  = 4'd6,
      R_REST  = 4'd7,
      R_GAP3  = 4'd8
   } state_t;

   state_t state;
   state_t state_n;

   // Pending CPU write slot
   logic       slot_full;
   logic       slot_sel;
   logic       slot_chip;
   logic [7:0] slot_data;
   logic       slot_full_n;
   logic       slot_sel_n;
   logic       slot_chip_n;
   logic [7:0] slot_data_n;

   // TurboSound select and per-chip register shadows
   logic            cur_chip;
   logic            cur_chip_n;
   logic [1:0][3:0] shadow;
   logic [1:0][3:0] shadow_n;

   // Latched replay request (the register number is consumed on acceptance)
   logic       rq_chip;
   logic [7:0] rq_data;
   logic       rq_chip_n;
   logic [7:0] rq_data_n;

   logic       ovr_n;

   // Next values of the registered bus outputs
   logic       bdir_n;
   logic       bc_n;
   logic [7:0] do_n;
   logic [1:0] a8_n;
   logic       chip_n;

   // Request decode
   logic       idle;
   logic       chip_sel_wr;
   logic       cap_wr;
   logic       drain;
   logic       slot_free;
   logic       direct;
   logic       rp_accept;

   // CPU op source: the slot if something is waiting, else the live strobe
   logic       op_sel;
   logic       op_chip;
   logic [7:0] op_data;

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   always_comb begin
      idle        = (state == IDLE);
      // FF / FE on the address port only switch the TurboSound chip select.
      chip_sel_wr = cpu_wr & cpu_sel_addr & (cpu_di[7:1] == 7'h7F);
      cap_wr      = cpu_wr & ~chip_sel_wr;
      // The slot empties into a bus op whenever the FSM leaves IDLE with it
      // full. A strobe in that same cycle refills it.
      drain       = idle & slot_full;
      slot_free   = ~slot_full | drain;
      // An idle arbiter with an empty slot issues the write at once, so the
      // write does not pass through the slot.
      direct      = idle & ~slot_full & cap_wr;
      rp_ready    = ~RESET & idle & ~slot_full & ~cpu_wr;
      rp_accept   = rp_valid & rp_ready;

      op_sel      = slot_full ? slot_sel  : cpu_sel_addr;
      op_chip     = slot_full ? slot_chip : cur_chip;
      op_data     = slot_full ? slot_data : cpu_di;
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state. A replay sequence is never interrupted; CPU writes that
   // arrive during it wait in the slot.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (slot_full | cap_wr) begin
               state_n = CPU_OP;
            end else if (rp_accept) begin
               state_n = R_ADDR;
            end
         end
         CPU_OP:  state_n = CPU_GAP;
         CPU_GAP: state_n = IDLE;
         R_ADDR:  state_n = R_GAP1;
         R_GAP1:  state_n = R_DATA;
         R_DATA:  state_n = R_GAP2;
         R_GAP2:  state_n = R_REST;
         R_REST:  state_n = R_GAP3;
         R_GAP3:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Slot, chip select, shadows, replay latch, overrun
   // ---------------------------------------------------------------------------
   always_comb begin
      slot_full_n = slot_full & ~drain;
      slot_sel_n  = slot_sel;
      slot_chip_n = slot_chip;
      slot_data_n = slot_data;
      cur_chip_n  = cur_chip;
      shadow_n    = shadow;
      rq_chip_n   = rq_chip;
      rq_data_n   = rq_data;
      ovr_n       = cpu_ovr;

      if (chip_sel_wr) begin
         cur_chip_n = ~cpu_di[0];            // FF -> chip 0, FE -> chip 1
      end

      if (cap_wr) begin
         if (slot_free) begin
            // The shadow follows the CPU's select when the write is accepted,
            // so a restore that is already running sees the new value.
            if (cpu_sel_addr) begin
               shadow_n[cur_chip] = cpu_di[3:0];
            end
            if (!direct) begin
               slot_full_n = 1'b1;
               slot_sel_n  = cpu_sel_addr;
               slot_chip_n = cur_chip;
               slot_data_n = cpu_di;
            end
         end else begin
            ovr_n = 1'b1;
         end
      end

      if (rp_accept) begin
         rq_chip_n = rp_chip;
         rq_data_n = rp_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Bus outputs, computed from the next state so that they are registered
   // yet still line up with the state they belong to.
   // ---------------------------------------------------------------------------
   always_comb begin
      bdir_n = 1'b0;
      bc_n   = 1'b0;
      chip_n = rq_chip_n;
      do_n   = psg_do;                       // hold through gaps and idle
      case (state_n)
         CPU_OP: begin
            bdir_n = 1'b1;
            bc_n   = op_sel;
            chip_n = op_chip;
            do_n   = op_data;
         end
         R_ADDR: begin
            bdir_n = 1'b1;
            bc_n   = 1'b1;
            do_n   = {4'h0, rp_reg};          // only entered on acceptance
         end
         R_DATA: begin
            bdir_n = 1'b1;
            do_n   = rq_data_n;
         end
         R_REST: begin
            bdir_n = 1'b1;
            bc_n   = 1'b1;
            do_n   = {4'h0, shadow_n[rq_chip_n]};
         end
         default: begin
         end
      endcase
      a8_n = bdir_n ? (chip_n ? 2'b10 : 2'b01) : 2'b00;
   end

   // ---------------------------------------------------------------------------
   // Datapath and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         slot_full <= 1'b0;
         slot_sel  <= 1'b0;
         slot_chip <= 1'b0;
         slot_data <= 8'h00;
         cur_chip  <= 1'b0;
         shadow    <= '0;
         rq_chip   <= 1'b0;
         rq_data   <= 8'h00;
         cpu_ovr   <= 1'b0;
         psg_bdir  <= 1'b0;
         psg_bc    <= 1'b0;
         psg_do    <= 8'h00;
         psg_a8    <= 2'b00;
      end else begin
         slot_full <= slot_full_n;
         slot_sel  <= slot_sel_n;
         slot_chip <= slot_chip_n;
         slot_data <= slot_data_n;
         cur_chip  <= cur_chip_n;
         shadow    <= shadow_n;
         rq_chip   <= rq_chip_n;
         rq_data   <= rq_data_n;
         cpu_ovr   <= ovr_n;
         psg_bdir  <= bdir_n;
         psg_bc    <= bc_n;
         psg_do    <= do_n;
         psg_a8    <= a8_n;
      end
   end

   assign rd_chip = cur_chip;

endmodule

// File: tb/tb_psg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_psg_bus_arbiter
//
// Directed scenarios followed by random traffic. Every cycle is compared
// against a reference model. The model keeps a queue of the bus cycles it
// expects next. An arbitration decision appends a whole op (pulse and gap
// cycles), and the model pops one entry per clock. A restore entry takes its
// byte from the model's shadow at the moment it is popped.
// -----------------------------------------------------------------------------
module tb_psg_bus_arbiter;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       cpu_wr = 1'b0;
   logic       cpu_sel_addr = 1'b0;
   logic [7:0] cpu_di = 8'h00;
   logic       rp_valid = 1'b0;
   logic       rp_ready;
   logic       rp_chip = 1'b0;
   logic [3:0] rp_reg = 4'h0;
   logic [7:0] rp_data = 8'h00;
   logic       psg_bdir;
   logic       psg_bc;
   logic [7:0] psg_do;
   logic [1:0] psg_a8;
   logic       rd_chip;
   logic       cpu_ovr;

   psg_bus_arbiter dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .cpu_wr       (cpu_wr),
      .cpu_sel_addr (cpu_sel_addr),
      .cpu_di       (cpu_di),
      .rp_valid     (rp_valid),
      .rp_ready     (rp_ready),
      .rp_chip      (rp_chip),
      .rp_reg       (rp_reg),
      .rp_data      (rp_data),
      .psg_bdir     (psg_bdir),
      .psg_bc       (psg_bc),
      .psg_do       (psg_do),
      .psg_a8       (psg_a8),
      .rd_chip      (rd_chip),
      .cpu_ovr      (cpu_ovr)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct {
      bit       bdir;
      bit       bc;
      bit       chip;
      bit [7:0] dbyte;
      bit       rest;
   } ent_t;

   ent_t     sched[$];
   bit       m_busy;
   bit       m_slot_full;
   bit       m_slot_sel;
   bit       m_slot_chip;
   bit [7:0] m_slot_data;
   bit       m_cur;
   bit [3:0] m_sh[2];
   bit       m_ovr;
   bit       e_bdir;
   bit       e_bc;
   bit [7:0] e_do;
   bit [1:0] e_a8;

   function automatic ent_t mk(input bit bdir, input bit bc, input bit chip,
                               input bit [7:0] dbyte, input bit rest);
      ent_t e;
      e.bdir = bdir; e.bc = bc; e.chip = chip; e.dbyte = dbyte; e.rest = rest;
      return e;
   endfunction

   task automatic push_cpu(input bit sel, input bit [7:0] d, input bit chip);
      sched.push_back(mk(1'b1, sel, chip, d, 1'b0));
      sched.push_back(mk(1'b0, 1'b0, chip, 8'h00, 1'b0));
   endtask

   task automatic push_rp(input bit c, input bit [3:0] r, input bit [7:0] d);
      sched.push_back(mk(1'b1, 1'b1, c, {4'h0, r}, 1'b0));
      sched.push_back(mk(1'b0, 1'b0, c, 8'h00, 1'b0));
      sched.push_back(mk(1'b1, 1'b0, c, d, 1'b0));
      sched.push_back(mk(1'b0, 1'b0, c, 8'h00, 1'b0));
      sched.push_back(mk(1'b1, 1'b1, c, 8'h00, 1'b1));
      sched.push_back(mk(1'b0, 1'b0, c, 8'h00, 1'b0));
   endtask

   // One clock: drive inputs, check rp_ready, advance model, check outputs.
   task automatic step(input bit wr, input bit sel, input bit [7:0] di, input bit rv,
                       input bit rc, input bit [3:0] rr, input bit [7:0] rd, input bit rst);
      bit   idle;
      bit   m_ready;
      bit   csw;
      bit   acc;
      ent_t e;
      @(negedge CLK);
      RESET = rst; cpu_wr = wr; cpu_sel_addr = sel; cpu_di = di;
      rp_valid = rv; rp_chip = rc; rp_reg = rr; rp_data = rd;
      #1;
      idle    = !m_busy;
      m_ready = !rst && idle && !m_slot_full && !wr;
      chk("rp_ready", rp_ready, m_ready);
      if (rst) begin
         sched.delete();
         m_busy = 0; m_slot_full = 0; m_cur = 0; m_sh[0] = 0; m_sh[1] = 0; m_ovr = 0;
         e_bdir = 0; e_bc = 0; e_do = 0; e_a8 = 0;
      end else begin
         csw = wr && sel && (di == 8'hFF || di == 8'hFE);
         if (csw) m_cur = (di == 8'hFE);
         acc = wr && !csw && (!m_slot_full || idle);
         if (wr && !csw && !acc) m_ovr = 1;
         if (acc && sel) m_sh[m_cur] = di[3:0];
         if (idle) begin
            if (m_slot_full) begin
               push_cpu(m_slot_sel, m_slot_data, m_slot_chip);
               m_slot_full = 0;
            end else if (acc) begin
               push_cpu(sel, di, m_cur);
               acc = 0;
            end else if (m_ready && rv) begin
               push_rp(rc, rr, rd);
            end
         end
         if (acc) begin
            m_slot_full = 1; m_slot_sel = sel; m_slot_data = di; m_slot_chip = m_cur;
         end
         if (sched.size() > 0) begin
            e      = sched.pop_front();
            m_busy = 1;
            e_bdir = e.bdir;
            e_bc   = e.bdir & e.bc;
            e_a8   = e.bdir ? (e.chip ? 2'b10 : 2'b01) : 2'b00;
            if (e.bdir) e_do = e.rest ? {4'h0, m_sh[e.chip]} : e.dbyte;
         end else begin
            m_busy = 0; e_bdir = 0; e_bc = 0; e_a8 = 0;
         end
      end
      @(posedge CLK);
      #1;
      chk("bdir", psg_bdir, e_bdir);
      chk("bc", psg_bc, e_bc);
      chk("do", psg_do, e_do);
      chk("a8", psg_a8, e_a8);
      chk("rd_chip", rd_chip, m_cur);
      chk("cpu_ovr", cpu_ovr, m_ovr);
   endtask

   task automatic cpu(input bit sel, input bit [7:0] di);
      step(1'b1, sel, di, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
   endtask

   task automatic nop();
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
   endtask

   task automatic rpq(input bit c, input bit [3:0] r, input bit [7:0] d);
      step(1'b0, 1'b0, 8'h00, 1'b1, c, r, d, 1'b0);
   endtask

   task automatic rst_cyc();
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      bit       wr;
      bit       sel;
      bit [7:0] di;

      // Reset
      rst_cyc();
      rst_cyc();
      chk("reset_bdir", psg_bdir, 1'b0);
      chk("reset_a8", psg_a8, 2'b00);
      chk("reset_do", psg_do, 8'h00);
      nop();

      // Address write 07 on chip 0
      cpu(1'b1, 8'h07);
      chk("a07_bdir", psg_bdir, 1'b1);
      chk("a07_bc", psg_bc, 1'b1);
      chk("a07_do", psg_do, 8'h07);
      chk("a07_a8", psg_a8, 2'b01);
      nop();
      chk("a07_gap", psg_bdir, 1'b0);
      nop();

      // FE selects chip 1 with no bus op; data write goes to chip 1
      cpu(1'b1, 8'hFE);
      chk("fe_nobus", psg_bdir, 1'b0);
      chk("fe_rd_chip", rd_chip, 1'b1);
      cpu(1'b0, 8'h3F);
      chk("d3f_bdir", psg_bdir, 1'b1);
      chk("d3f_bc", psg_bc, 1'b0);
      chk("d3f_do", psg_do, 8'h3F);
      chk("d3f_a8", psg_a8, 2'b10);
      nop(); nop();

      // Chip 0 reg 8 selected, then replay {chip0, reg2, A5}
      cpu(1'b1, 8'hFF);
      cpu(1'b1, 8'h08);
      nop(); nop();
      rpq(1'b0, 4'h2, 8'hA5);
      chk("rp_addr_bc", psg_bc, 1'b1);
      chk("rp_addr_do", psg_do, 8'h02);
      nop(); nop();
      chk("rp_data_bc", psg_bc, 1'b0);
      chk("rp_data_do", psg_do, 8'hA5);
      nop(); nop();
      chk("rp_rest_bc", psg_bc, 1'b1);
      chk("rp_rest_do", psg_do, 8'h08);
      nop(); nop();
      chk("rp_ready_again", rp_ready, 1'b1);

      // Simultaneous CPU write and replay request: CPU first
      step(1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 4'h9, 8'h66, 1'b0);
      chk("tie_cpu_do", psg_do, 8'h55);
      rpq(1'b1, 4'h9, 8'h66);
      rpq(1'b1, 4'h9, 8'h66);
      rpq(1'b1, 4'h9, 8'h66);
      chk("tie_rp_do", psg_do, 8'h09);
      chk("tie_rp_a8", psg_a8, 2'b10);
      repeat (6) nop();

      // Address write 0B during R_DATA: restore uses it, CPU op follows
      rpq(1'b0, 4'h3, 8'h11);
      nop(); nop();
      cpu(1'b1, 8'h0B);
      nop();
      chk("late_rest_do", psg_do, 8'h0B);
      nop(); nop(); nop();
      chk("late_cpu_bdir", psg_bdir, 1'b1);
      chk("late_cpu_do", psg_do, 8'h0B);
      nop(); nop();

      // Overrun, then reset during R_DATA
      rpq(1'b1, 4'h5, 8'h77);
      cpu(1'b0, 8'h11);
      nop();
      cpu(1'b0, 8'h22);
      chk("ovr_set", cpu_ovr, 1'b1);
      repeat (6) nop();
      chk("ovr_sticky", cpu_ovr, 1'b1);
      rpq(1'b0, 4'h1, 8'h33);
      nop(); nop();
      rst_cyc();
      chk("rst_mid_bdir", psg_bdir, 1'b0);
      chk("rst_mid_a8", psg_a8, 2'b00);
      chk("rst_mid_ovr", cpu_ovr, 1'b0);
      nop();
      chk("rst_mid_idle", rp_ready, 1'b1);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         wr  = ($urandom_range(0, 6) == 0);
         sel = $urandom_range(0, 1);
         di  = 8'($urandom_range(0, 255));
         if (sel && $urandom_range(0, 3) == 0) di = $urandom_range(0, 1) ? 8'hFF : 8'hFE;
         if ($urandom_range(0, 299) == 0) begin
            rst_cyc();
         end else begin
            step(wr, sel, di, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
